// File: rtl/rx_frame_decoder.sv
// UART frame decoder: SYNC, LEN, payload, CHK -> buffered valid/ready stream.
// Define RX_FRAME_TIMEOUT_EN to build the inter-byte timeout counter.
module rx_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_done,
    input  logic [7:0] i_byte,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    input  logic       i_ready,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam int W  = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  idx, idx_nx;
    logic [W-1:0]  len, len_nx;
    logic [7:0]    sum, sum_nx;
    logic [7:0]    mem [MAX_LEN];
    logic [AW-1:0] ptr;
    logic          last;
    logic          wr_en;
    logic          ok_nx, err_nx, ovr_nx;
    logic          tmo;

    assign ptr     = idx[AW-1:0];
    assign last    = (idx == len - ONE);
    assign o_valid = (state == S_DRAIN);
    assign o_data  = o_valid ? mem[ptr] : 8'h00;
    assign o_last  = o_valid && last;
    assign o_busy  = (state != S_HUNT);

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          timed;

    assign timed = state inside {S_LEN, S_PAYLOAD, S_CHECK};
    assign tmo   = timed && !i_done &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Idle time between bytes only; DRAIN waits on the consumer.
    always_ff @(posedge clk) begin
        if (!reset_n || i_done || !timed)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo        = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        len_nx   = len;
        sum_nx   = sum;
        wr_en    = 1'b0;
        ok_nx    = 1'b0;
        err_nx   = 1'b0;
        ovr_nx   = 1'b0;
        unique case (state)
            S_HUNT: begin
                if (i_done && i_byte == SYNC_BYTE)
                    state_nx = S_LEN;
            end
            S_LEN: begin
                if (i_done) begin
                    if (i_byte == 8'h00 || i_byte > 8'(MAX_LEN)) begin
                        err_nx   = 1'b1;
                        state_nx = S_HUNT;
                    end else begin
                        len_nx   = i_byte[W-1:0];
                        sum_nx   = 8'h00;
                        idx_nx   = '0;
                        state_nx = S_PAYLOAD;
                    end
                end else if (tmo) begin
                    err_nx   = 1'b1;
                    state_nx = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (i_done) begin
                    wr_en  = 1'b1;
                    sum_nx = sum + i_byte;
                    idx_nx = idx + ONE;
                    if (last)
                        state_nx = S_CHECK;
                end else if (tmo) begin
                    err_nx   = 1'b1;
                    state_nx = S_HUNT;
                end
            end
            S_CHECK: begin
                if (i_done) begin
                    if (i_byte == sum) begin
                        ok_nx    = 1'b1;
                        idx_nx   = '0;
                        state_nx = S_DRAIN;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = S_HUNT;
                    end
                end else if (tmo) begin
                    err_nx   = 1'b1;
                    state_nx = S_HUNT;
                end
            end
            S_DRAIN: begin
                // Any byte here is dropped, SYNC included.
                ovr_nx = i_done;
                if (i_ready) begin
                    idx_nx = idx + ONE;
                    if (last)
                        state_nx = S_HUNT;
                end
            end
            default: state_nx = S_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_HUNT;
            idx         <= '0;
            len         <= '0;
            sum         <= 8'h00;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            len         <= len_nx;
            sum         <= sum_nx;
            o_frame_ok  <= ok_nx;
            o_frame_err <= err_nx;
            o_overrun   <= ovr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ptr] <= i_byte;
    end
endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder with an output-byte scoreboard.
module tb_rx_frame_decoder;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_done;
    logic [7:0] i_byte;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic       i_ready;
    logic       o_frame_ok;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int ok0, err0, ovr0;

    logic [8:0] exp_q[$];
    logic [7:0] pl[$];
    logic       hold_v = 1'b0;
    logic [8:0] hold_d = '0;

    rx_frame_decoder #(
        .SYNC_BYTE(SYNC),
        .MAX_LEN(16),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_done(i_done),
        .i_byte(i_byte),
        .o_valid(o_valid),
        .o_data(o_data),
        .o_last(o_last),
        .i_ready(i_ready),
        .o_frame_ok(o_frame_ok),
        .o_frame_err(o_frame_err),
        .o_overrun(o_overrun),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        step();
        i_done = 1'b1;
        i_byte = b;
        step();
        i_done = 1'b0;
        i_byte = 8'h00;
    endtask

    task automatic frame(input bit good);
        logic [7:0] s;
        s = 8'h00;
        send(SYNC);
        send(8'(pl.size()));
        foreach (pl[i]) begin
            send(pl[i]);
            s += pl[i];
            if (good)
                exp_q.push_back({i == pl.size() - 1, pl[i]});
        end
        send(good ? s : ~s);
    endtask

    task automatic drain_wait(input int max);
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0 && !o_busy)
                break;
            step();
        end
        chk("drain_done", 32'({exp_q.size() != 0, o_busy}), 32'd0);
    endtask

    task automatic snap();
        ok0  = ok_cnt;
        err0 = err_cnt;
        ovr0 = ovr_cnt;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (o_frame_ok)  ok_cnt++;
            if (o_frame_err) err_cnt++;
            if (o_overrun)   ovr_cnt++;
            if (o_frame_ok || o_frame_err || o_overrun)
                chk("pulse_excl",
                    32'(o_frame_ok) + 32'(o_frame_err) + 32'(o_overrun), 32'd1);
            if (hold_v)
                chk("hold", 32'({o_valid, o_last, o_data}), 32'({1'b1, hold_d}));
            hold_v = o_valid && !i_ready;
            hold_d = {o_last, o_data};
            if (o_valid && i_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    chk("beat", 32'({o_last, o_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        i_done  = 1'b0;
        i_byte  = 8'h00;
        i_ready = 1'b1;
        repeat (3) step();
        chk("reset_outs", 32'({o_valid, o_data, o_last, o_frame_ok,
            o_frame_err, o_overrun, o_busy}), 32'd0);
        reset_n = 1'b1;
        step();

        // basic frame, consecutive beats
        snap();
        pl = '{8'h10, 8'h20, 8'h30};
        frame(1'b1);
        chk("t1_ok", 32'({o_frame_ok, o_valid, o_data, o_last}),
            32'({2'b11, 8'h10, 1'b0}));
        step();
        chk("t1_b1", 32'({o_frame_ok, o_valid, o_data, o_last}),
            32'({2'b01, 8'h20, 1'b0}));
        step();
        chk("t1_b2", 32'({o_valid, o_data, o_last}), 32'({1'b1, 8'h30, 1'b1}));
        step();
        chk("t1_end", 32'({o_valid, o_busy}), 32'd0);
        chk("t1_okcnt", 32'(ok_cnt - ok0), 32'd1);

        // checksum wraps, wrong CHK
        snap();
        send(SYNC); send(8'h02); send(8'hFF); send(8'h02); send(8'h00);
        chk("t2_err", 32'({o_frame_err, o_valid, o_busy}), 32'b100);
        step();
        chk("t2_after", 32'({o_frame_err, o_valid, o_busy}), 32'd0);
        chk("t2_errcnt", 32'(err_cnt - err0), 32'd1);

        // bad lengths
        snap();
        send(SYNC); send(8'h00);
        chk("t3_len0", 32'({o_frame_err, o_busy}), 32'b10);
        send(SYNC); send(8'h11);
        chk("t3_len17", 32'({o_frame_err, o_busy}), 32'b10);
        step();
        chk("t3_cnt", 32'({err_cnt - err0, ok_cnt - ok0}), 32'({32'd2, 32'd0}) & 32'hFFFF_FFFF);
        chk("t3_novalid", 32'(o_valid), 32'd0);

        // backpressure with overrun
        snap();
        i_ready = 1'b0;
        pl = '{8'h55, 8'hAA};
        frame(1'b1);
        repeat (3) step();
        chk("t4_stall", 32'({o_valid, o_data, o_last}), 32'({1'b1, 8'h55, 1'b0}));
        send(SYNC);
        chk("t4_ovr", 32'({o_overrun, o_busy, o_data}), 32'({2'b11, 8'h55}));
        repeat (4) step();
        i_ready = 1'b1;
        drain_wait(20);
        chk("t4_cnt", 32'({8'(ovr_cnt - ovr0), 8'(ok_cnt - ok0)}), 32'h0101);

        // i_done on the final handshake, then HUNT immediately
        snap();
        pl = '{8'h5A};
        frame(1'b1);
        i_done = 1'b1;
        i_byte = SYNC;
        step();
        i_done = 1'b0;
        chk("t4b_ovr", 32'({o_overrun, o_busy, o_valid}), 32'b100);
        pl.delete();
        for (int i = 0; i < 16; i++)
            pl.push_back(8'($urandom));
        frame(1'b1);
        drain_wait(40);
        chk("t4b_cnt", 32'({8'(ovr_cnt - ovr0), 8'(ok_cnt - ok0)}), 32'h0102);

        // reset mid-payload
        snap();
        send(SYNC); send(8'h03); send(8'h11);
        chk("t5_busy", 32'(o_busy), 32'd1);
        reset_n = 1'b0;
        step();
        chk("t5_reset", 32'({o_valid, o_data, o_last, o_frame_ok,
            o_frame_err, o_overrun, o_busy}), 32'd0);
        reset_n = 1'b1;
        pl = '{8'h07, 8'h08, 8'h09};
        frame(1'b1);
        drain_wait(20);
        chk("t5_cnt", 32'({8'(err_cnt - err0), 8'(ok_cnt - ok0)}), 32'h0001);

`ifdef RX_FRAME_TIMEOUT_EN
        snap();
        send(SYNC); send(8'h04); send(8'h01);
        repeat (49) step();
        chk("t6_before", 32'({o_frame_err, o_busy}), 32'b01);
        step();
        chk("t6_at", 32'({o_frame_err, o_busy}), 32'b10);
        step();
        chk("t6_cnt", 32'(err_cnt - err0), 32'd1);
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
